pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter and sequences next-PC selection for the fetch stage.
//  Arbitrates redirect requests from decode (j/jal, taken branch, jr) and from the
//  exception unit. Forms the jump target as {PC+4[31:28], target26, 2'b00}.
//  Holds requests that arrive during a stall and applies them when fetch resumes.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  EXC_VECTOR  32'h8000_0180  PC value loaded on exception
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-high
//  stall          in   1   1 = hold PC (fetch frozen)
//  req_pc         in   32  address of the instruction issuing jump, branch or jr
//  jump           in   1   j/jal decoded this cycle
//  jump_target    in   26  instr[25:0]
//  branch         in   1   branch decoded this cycle
//  branch_taken   in   1   branch condition true (ignored unless branch=1)
//  branch_offset  in   16  instr[15:0], signed word offset
//  jr             in   1   jr/jalr decoded this cycle
//  jr_addr        in   32  register target
//  exc            in   1   exception request, highest priority
//  pc             out  32  current fetch address
//  pc_plus4       out  32  pc + 4
//  flush          out  1   kill the instruction fetched this cycle (one-cycle pulse)
//  pending        out  1   redirect latched, waiting for stall release
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=RUN, flush=0, pending=0, latched target cleared.
//  Targets: jmp={req_pc+4}[31:28],jump_target,2'b00; br=req_pc+4+(sext(off)<<2);
//   jr=jr_addr. All arithmetic is mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
//  Priority: exc > jr > jump > (branch & branch_taken) > sequential pc+4.
//  FSM RUN: stall=0 -> pc <= winning target, or pc+4 if there is no request.
//   stall=1 with a request -> latch the target, go to PEND, pending=1, pc held.
//   stall=1 with no request -> pc held.
//  FSM PEND: stall=1 -> hold. A new exc overwrites the latched target.
//   Other new requests are ignored. stall=0 -> pc <= latched target (or EXC_VECTOR if
//   exc is asserted this cycle), go to RUN, pending=0.
//  Latency: redirect is visible on pc the cycle after acceptance (1 cycle).
//  exc never uses the delay slot. It always flushes, and pc <= EXC_VECTOR even when stalled.
//  Requests with req_pc inconsistent with pc are not checked; decode owns that.
//  Reset mid-PEND discards the latched target.
// CONFIGURATION
//  PC_SEQ_DELAY_SLOT_EN defined: MIPS delay-slot semantics. The instruction at
//   req_pc+4 is kept, and flush=0 for jr, jump and branch redirects.
//  Undefined: no delay slot. flush=1 in the cycle a jr, jump or taken-branch
//   redirect is applied (RUN accept, or PEND release).
//  exc flushes in both builds.
// STRUCTURE
//  Shared include pc_seq_defs.vh: state encodings RUN=1'b0 and PEND=1'b1.
//   It also holds the default RESET_PC and EXC_VECTOR constants and the SEL_* next-PC select codes.
//  Sub-module jump_target_gen: combinational jump, branch and jr target formation, plus the
//   priority mux. The FSM and PC register stay in pc_sequencer.
// TESTING
//  1 Reset, then 4 free cycles: pc goes 0 -> 4 -> 8 -> C -> 10. Assert reset mid-run: pc=0 immediately.
//  2 jump=1, req_pc=32'h0040_0010, jump_target=26'h010_0040: next pc=32'h0040_0100.
//    flush=1 without the macro, 0 with it.
//  3 branch taken, req_pc=32'h0000_0100, off=16'hFFFE: next pc=32'h0000_00FC. Repeat with
//    branch_taken=0: pc = pc+4.
//  4 jr=1, jump=1 and exc=1 together: pc=EXC_VECTOR and flush=1. Drop exc: jr_addr wins over jump.
//  5 stall=1 for 3 cycles, jr (jr_addr=32'h1234_5678) in cycle 1, jump in cycle 2.
//    pending=1 and pc is held. On release, pc=32'h1234_5678 (jump ignored) and pending=0.
//  6 pc=32'hFFFF_FFFC, no request: next pc=0. An exc while in PEND overrides the
//    latched target: pc=EXC_VECTOR.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// State encodings, default reset/exception vectors and next-PC select codes.
package pc_sequencer_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned JT_W   = 26;
    localparam int unsigned OFF_W  = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF = 32'h8000_0180;

    // Sequencer FSM encodings
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Next-PC select codes, in rising priority order
    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_BR  = 3'd1,
        SEL_JMP = 3'd2,
        SEL_JR  = 3'd3,
        SEL_EXC = 3'd4
    } sel_e;

    // Branch target: address of the delay-slot instruction plus sign-extended word offset
    function automatic logic [ADDR_W-1:0] br_target(input logic [ADDR_W-1:0] req_pc,
                                                    input logic [OFF_W-1:0]  off);
        return req_pc + ADDR_W'(4) + {{(ADDR_W-OFF_W-2){off[OFF_W-1]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage redirect bus between decode/exception logic and the PC sequencer.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic              stall;
    logic [ADDR_W-1:0] req_pc;
    logic              jump;
    logic [JT_W-1:0]   jump_target;
    logic              branch;
    logic              branch_taken;
    logic [OFF_W-1:0]  branch_offset;
    logic              jr;
    logic [ADDR_W-1:0] jr_addr;
    logic              exc;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              flush;
    logic              pending;

    // Request side (decode, exception unit)
    modport master (
        output stall, req_pc, jump, jump_target, branch, branch_taken,
               branch_offset, jr, jr_addr, exc,
        input  pc, pc_plus4, flush, pending
    );

    // Sequencer side
    modport slave (
        input  stall, req_pc, jump, jump_target, branch, branch_taken,
               branch_offset, jr, jr_addr, exc,
        output pc, pc_plus4, flush, pending
    );

endinterface

// File: rtl/pc_sequencer_jump_target_gen.sv
// Combinational redirect target formation and priority select.
// Priority: exc > jr > jump > taken branch > sequential (no redirect).
module pc_sequencer_jump_target_gen
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [ADDR_W-1:0] i_req_pc,
    input  logic              i_jump,
    input  logic [JT_W-1:0]   i_jump_target,
    input  logic              i_branch,
    input  logic              i_branch_taken,
    input  logic [OFF_W-1:0]  i_branch_offset,
    input  logic              i_jr,
    input  logic [ADDR_W-1:0] i_jr_addr,
    input  logic              i_exc,
    output logic [ADDR_W-1:0] o_target_c,
    output sel_e              o_sel_c
);

    logic [ADDR_W-1:0] w_jmp;
    logic [ADDR_W-1:0] w_br;

    // Jump keeps the region bits of the delay-slot address; branch is PC-relative
    always_comb begin
        w_jmp = {4'((i_req_pc + ADDR_W'(4)) >> 28), i_jump_target, 2'b00};
        w_br  = br_target(i_req_pc, i_branch_offset);
    end

    // Priority select of the winning redirect
    always_comb begin
        o_sel_c    = SEL_SEQ;
        o_target_c = '0;
        if (i_exc) begin
            o_sel_c    = SEL_EXC;
            o_target_c = EXC_VECTOR;
        end else if (i_jr) begin
            o_sel_c    = SEL_JR;
            o_target_c = i_jr_addr;
        end else if (i_jump) begin
            o_sel_c    = SEL_JMP;
            o_target_c = w_jmp;
        end else if (i_branch && i_branch_taken) begin
            o_sel_c    = SEL_BR;
            o_target_c = w_br;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and next-PC sequencer for the fetch stage.
// Redirects arriving under stall are latched and applied on release; exceptions
// take effect immediately, even when stalled, and discard any latched redirect.
// flush is registered: it rises together with the redirected pc and kills the
// instruction captured by the previous fetch cycle.
// Build option: PC_SEQ_DELAY_SLOT_EN keeps the delay-slot instruction
// (no flush on jr/jump/branch); undefined, those redirects flush.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

`ifdef PC_SEQ_DELAY_SLOT_EN
    localparam logic REDIR_FLUSH = 1'b0;
`else
    localparam logic REDIR_FLUSH = 1'b1;
`endif

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_plus4;
    logic [ADDR_W-1:0] r_latch;
    logic              r_flush;
    logic              r_pending;

    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_latch_nxt;
    logic              w_flush_nxt;
    logic              w_pending_nxt;
    logic [ADDR_W-1:0] w_target;
    sel_e              w_sel;

    pc_sequencer_jump_target_gen #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_tgt (
        .i_req_pc        (bus.req_pc),
        .i_jump          (bus.jump),
        .i_jump_target   (bus.jump_target),
        .i_branch        (bus.branch),
        .i_branch_taken  (bus.branch_taken),
        .i_branch_offset (bus.branch_offset),
        .i_jr            (bus.jr),
        .i_jr_addr       (bus.jr_addr),
        .i_exc           (bus.exc),
        .o_target_c      (w_target),
        .o_sel_c         (w_sel)
    );

    // Next-state, next-PC and output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_latch_nxt   = r_latch;
        w_flush_nxt   = 1'b0;
        w_pending_nxt = r_pending;
        if (w_sel == SEL_EXC) begin
            w_pc_nxt      = w_target;
            w_flush_nxt   = 1'b1;
            w_state_nxt   = ST_RUN;
            w_latch_nxt   = '0;
            w_pending_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (w_sel != SEL_SEQ) begin
                            w_pc_nxt    = w_target;
                            w_flush_nxt = REDIR_FLUSH;
                        end else begin
                            w_pc_nxt = r_pc + ADDR_W'(4);
                        end
                    end else if (w_sel != SEL_SEQ) begin
                        w_latch_nxt   = w_target;
                        w_state_nxt   = ST_PEND;
                        w_pending_nxt = 1'b1;
                    end
                end
                ST_PEND: begin
                    if (!bus.stall) begin
                        w_pc_nxt      = r_latch;
                        w_flush_nxt   = REDIR_FLUSH;
                        w_state_nxt   = ST_RUN;
                        w_pending_nxt = 1'b0;
                        w_latch_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State, PC and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + ADDR_W'(4);
            r_latch    <= '0;
            r_flush    <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_plus4 <= w_pc_nxt + ADDR_W'(4);
            r_latch    <= w_latch_nxt;
            r_flush    <= w_flush_nxt;
            r_pending  <= w_pending_nxt;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_plus4 = r_pc_plus4;
    assign bus.flush    = r_flush;
    assign bus.pending  = r_pending;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each task pushes the expected pc/flush/pending
// when it drives a cycle and pops/compares once the DUT has clocked.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_PC = 32'h8000_0180;
`ifdef PC_SEQ_DELAY_SLOT_EN
    localparam logic RF = 1'b0;
`else
    localparam logic RF = 1'b1;
`endif

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        flush;
        logic        pending;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic e, input logic r,
                         input logic j, input logic b, input logic t);
        bus.stall        = s;
        bus.exc          = e;
        bus.jr           = r;
        bus.jump         = j;
        bus.branch       = b;
        bus.branch_taken = t;
    endtask

    task automatic push(input string tag, input logic [31:0] pc,
                        input logic fl, input logic pd);
        exp_t e;
        e.tag = tag; e.pc = pc; e.flush = fl; e.pending = pd;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] want_p4;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin push("reset_state", RST_PC, 1'b0, 1'b0); end
                1, 2, 3, 4: begin
                    reset = 1'b0;
                    push($sformatf("free_run_%0d", i), RST_PC + 32'(4 * i), 1'b0, 1'b0);
                    tick();
                end
                default: begin
                    push("async_reset", RST_PC, 1'b0, 1'b0);
                    reset = 1'b1;
                    #1;
                end
            endcase
            e = exp_q.pop_front();
            want_p4 = e.pc + 32'd4;
            n_vec++;
            if (bus.pc !== e.pc || bus.pc_plus4 !== want_p4 ||
                bus.flush !== e.flush || bus.pending !== e.pending) begin
                n_err++;
                $display("FAIL %s: got pc=%h p4=%h flush=%b pending=%b, want pc=%h p4=%h flush=%b pending=%b",
                         e.tag, bus.pc, bus.pc_plus4, bus.flush, bus.pending,
                         e.pc, want_p4, e.flush, e.pending);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_jump();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                bus.req_pc      = 32'h0040_0010;
                bus.jump_target = 26'h010_0040;
                drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                push("jump", 32'h0040_0100, RF, 1'b0);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                push("jump_seq", 32'h0040_0104, 1'b0, 1'b0);
            end
            tick();
            e = exp_q.pop_front();
            n_vec++;
            if (bus.pc !== e.pc || bus.pc_plus4 !== e.pc + 32'd4 ||
                bus.flush !== e.flush || bus.pending !== e.pending) begin
                n_err++;
                $display("FAIL %s: got pc=%h flush=%b pending=%b, want pc=%h flush=%b pending=%b",
                         e.tag, bus.pc, bus.flush, bus.pending, e.pc, e.flush, e.pending);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [15:0] off;
        logic [31:0] want;
        off = 16'hFFFE;
        want = 32'h0000_0100 + 32'd4 + {{14{off[15]}}, off, 2'b00};
        for (int i = 0; i < 2; i++) begin
            bus.req_pc        = 32'h0000_0100;
            bus.branch_offset = off;
            if (i == 0) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                push("branch_taken", want, RF, 1'b0);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                push("branch_not_taken", want + 32'd4, 1'b0, 1'b0);
            end
            tick();
            e = exp_q.pop_front();
            n_vec++;
            if (bus.pc !== e.pc || bus.flush !== e.flush || bus.pending !== e.pending) begin
                n_err++;
                $display("FAIL %s: got pc=%h flush=%b pending=%b, want pc=%h flush=%b pending=%b",
                         e.tag, bus.pc, bus.flush, bus.pending, e.pc, e.flush, e.pending);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        bus.jr_addr     = 32'h0000_2000;
        bus.jump_target = 26'h3FF_FFFF;
        bus.req_pc      = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                    push("exc_wins", EXC_PC, 1'b1, 1'b0);
                end
                1: begin
                    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                    push("jr_over_jump", 32'h0000_2000, RF, 1'b0);
                end
                default: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    push("prio_seq", 32'h0000_2004, 1'b0, 1'b0);
                end
            endcase
            tick();
            e = exp_q.pop_front();
            n_vec++;
            if (bus.pc !== e.pc || bus.flush !== e.flush || bus.pending !== e.pending) begin
                n_err++;
                $display("FAIL %s: got pc=%h flush=%b pending=%b, want pc=%h flush=%b pending=%b",
                         e.tag, bus.pc, bus.flush, bus.pending, e.pc, e.flush, e.pending);
            end
        end
    endtask

    task automatic test_stall_pend();
        exp_t e;
        logic [31:0] held;
        held = 32'h0000_2004;
        bus.jr_addr     = 32'h1234_5678;
        bus.jump_target = 26'h000_0100;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin
                    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    push("stall_jr_latch", held, 1'b0, 1'b1);
                end
                1: begin
                    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                    push("stall_jump_ignored", held, 1'b0, 1'b1);
                end
                2: begin
                    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    push("stall_hold", held, 1'b0, 1'b1);
                end
                3: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    push("pend_release", 32'h1234_5678, RF, 1'b0);
                end
                default: begin
                    push("after_release", 32'h1234_567C, 1'b0, 1'b0);
                end
            endcase
            tick();
            e = exp_q.pop_front();
            n_vec++;
            if (bus.pc !== e.pc || bus.flush !== e.flush || bus.pending !== e.pending) begin
                n_err++;
                $display("FAIL %s: got pc=%h flush=%b pending=%b, want pc=%h flush=%b pending=%b",
                         e.tag, bus.pc, bus.flush, bus.pending, e.pc, e.flush, e.pending);
            end
        end
    endtask

    task automatic test_wrap_exc_pend();
        exp_t e;
        bus.jr_addr     = 32'hFFFF_FFFC;
        bus.jump_target = 26'h000_0010;
        bus.req_pc      = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin
                    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    push("jr_to_top", 32'hFFFF_FFFC, RF, 1'b0);
                end
                1: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    push("wrap_to_zero", 32'h0000_0000, 1'b0, 1'b0);
                end
                2: begin
                    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                    push("stall_jump_latch", 32'h0000_0000, 1'b0, 1'b1);
                end
                3: begin
                    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    push("exc_in_pend", EXC_PC, 1'b1, 1'b0);
                end
                default: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    push("exc_then_seq", EXC_PC + 32'd4, 1'b0, 1'b0);
                end
            endcase
            tick();
            e = exp_q.pop_front();
            n_vec++;
            if (bus.pc !== e.pc || bus.pc_plus4 !== e.pc + 32'd4 ||
                bus.flush !== e.flush || bus.pending !== e.pending) begin
                n_err++;
                $display("FAIL %s: got pc=%h p4=%h flush=%b pending=%b, want pc=%h flush=%b pending=%b",
                         e.tag, bus.pc, bus.pc_plus4, bus.flush, bus.pending,
                         e.pc, e.flush, e.pending);
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        exp_t e;
        bus.jr_addr = 32'h0000_ABC0;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    push("pend_before_reset", EXC_PC + 32'd4, 1'b0, 1'b1);
                    tick();
                end
                1: begin
                    push("reset_in_pend", RST_PC, 1'b0, 1'b0);
                    reset = 1'b1;
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    #1;
                end
                default: begin
                    reset = 1'b0;
                    push("latch_discarded", RST_PC + 32'd4, 1'b0, 1'b0);
                    tick();
                end
            endcase
            e = exp_q.pop_front();
            n_vec++;
            if (bus.pc !== e.pc || bus.flush !== e.flush || bus.pending !== e.pending) begin
                n_err++;
                $display("FAIL %s: got pc=%h flush=%b pending=%b, want pc=%h flush=%b pending=%b",
                         e.tag, bus.pc, bus.flush, bus.pending, e.pc, e.flush, e.pending);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.req_pc        = '0;
        bus.jump_target   = '0;
        bus.branch_offset = '0;
        bus.jr_addr       = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        test_reset();
        test_jump();
        test_branch();
        test_priority();
        test_stall_pend();
        test_wrap_exc_pend();
        test_reset_mid_pend();

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
